// File: rtl/teclado_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Optional feature: TECLADO_MAPA_HEX_EN maps key positions to printed hex legends.
package teclado_pkg;

  typedef enum logic [1:0] {
    ESCANEO,
    REBOTE,
    PRESIONADA,
    SOLTAR
  } estado_t;

  // Default timing: 1 ms scan tick at 50 MHz, 20 ms debounce window.
  localparam int PRESC_LIM_DEF = 49999;
  localparam int DEB_CNT_DEF   = 20;

  // Printed legend of each position K = F*4 + C (row-major, standard phone-style pad).
  localparam logic [3:0] MAPA_HEX [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Lowest-index active row wins when several rows are pressed at once.
  function automatic logic [1:0] fila_activa(input logic [3:0] r);
    logic [1:0] f;
    if (r[0])      f = 2'd0;
    else if (r[1]) f = 2'd1;
    else if (r[2]) f = 2'd2;
    else           f = 2'd3;
    return f;
  endfunction

  // Code presented to the consumer for row F, column C.
  function automatic logic [3:0] codigo_tecla(input logic [1:0] f, input logic [1:0] c);
`ifdef TECLADO_MAPA_HEX_EN
    return MAPA_HEX[{f, c}];
`else
    return {f, c};
`endif
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Free-running prescaler producing a one-cycle tick every PRESC_LIM+1 clocks.
module divisor_tick
  import teclado_pkg::*;
#(
  parameter int PRESC_LIM = PRESC_LIM_DEF
) (
  input  logic i_Clk,
  input  logic i_Rst,
  output logic o_Tick
);

  localparam int W = (PRESC_LIM > 0) ? $clog2(PRESC_LIM + 1) : 1;
  localparam logic [W-1:0] LIM = W'(PRESC_LIM);

  logic [W-1:0] cnt_reg;

  // Count 0..PRESC_LIM and wrap; the tick marks the last count of each period.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)               cnt_reg <= '0;
    else if (cnt_reg == LIM) cnt_reg <= '0;
    else                     cnt_reg <= cnt_reg + 1'b1;
  end

  assign o_Tick = (cnt_reg == LIM);

endmodule

// File: rtl/escaner_teclado_4x4.sv
// 4x4 keypad scanner: column drive, row synchronizer, debounce FSM and
// ready/ack handshake. Define TECLADO_MAPA_HEX_EN to report printed hex legends
// instead of raw position indices.
module escaner_teclado_4x4
  import teclado_pkg::*;
#(
  parameter int PRESC_LIM = PRESC_LIM_DEF,
  parameter int DEB_CNT   = DEB_CNT_DEF
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Filas,
  input  logic       i_Ack,
  output logic [3:0] o_Columnas,
  output logic [3:0] o_Tecla,
  output logic       o_Listo,
  output logic       o_Sobrecarga
);

  localparam int CW = $clog2(DEB_CNT + 1);
  localparam logic [CW-1:0] DEB_LIM = CW'(DEB_CNT);

  logic          tick;
  logic [3:0]    filas_s1_reg, filas_s2_reg;
  logic [3:0]    filas_act;
  estado_t       estado_reg, estado_next;
  logic [1:0]    col_reg, col_next;
  logic [1:0]    fila_reg, fila_next;
  logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [3:0]    tecla_reg;
  logic          listo_reg, sobre_reg;

  divisor_tick #(.PRESC_LIM(PRESC_LIM)) u_divisor_tick (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .o_Tick (tick)
  );

  // Two-flop synchronizer for the asynchronous row lines (idle = pulled high).
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      filas_s1_reg <= 4'hF;
      filas_s2_reg <= 4'hF;
    end else begin
      filas_s1_reg <= i_Filas;
      filas_s2_reg <= filas_s1_reg;
    end
  end

  assign filas_act = ~filas_s2_reg;
  assign cnt_inc   = cnt_reg + 1'b1;

  // State register plus the column/row/debounce datapath it steers.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      estado_reg <= ESCANEO;
      col_reg    <= 2'd0;
      fila_reg   <= 2'd0;
      cnt_reg    <= '0;
    end else begin
      estado_reg <= estado_next;
      col_reg    <= col_next;
      fila_reg   <= fila_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Next-state logic; rows are only judged on ticks, after a full column period of settling.
  always_comb begin
    estado_next = estado_reg;
    col_next    = col_reg;
    fila_next   = fila_reg;
    cnt_next    = cnt_reg;
    case (estado_reg)
      ESCANEO: begin
        if (tick) begin
          if (filas_act != 4'd0) begin
            fila_next   = fila_activa(filas_act);
            cnt_next    = '0;
            estado_next = REBOTE;
          end else begin
            col_next = col_reg + 2'd1;
          end
        end
      end
      REBOTE: begin
        if (tick) begin
          if (filas_act[fila_reg]) begin
            cnt_next = cnt_inc;
            if (cnt_inc == DEB_LIM) estado_next = PRESIONADA;
          end else begin
            // Bounce: resume scanning on the same column.
            estado_next = ESCANEO;
          end
        end
      end
      PRESIONADA: begin
        cnt_next    = '0;
        estado_next = SOLTAR;
      end
      SOLTAR: begin
        if (tick) begin
          if (filas_act == 4'd0) begin
            cnt_next = cnt_inc;
            if (cnt_inc == DEB_LIM) begin
              estado_next = ESCANEO;
              col_next    = col_reg + 2'd1;
            end
          end else begin
            cnt_next = '0;
          end
        end
      end
      default: estado_next = ESCANEO;
    endcase
  end

  // Column drive: one-hot active-low from the current column index.
  always_comb begin
    o_Columnas = ~(4'b0001 << col_reg);
  end

  // Handshake: a fresh key loads the code unless one is still pending; an ack
  // arriving in the same cycle frees the slot first, so the new key is kept.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      tecla_reg <= 4'd0;
      listo_reg <= 1'b0;
      sobre_reg <= 1'b0;
    end else if (estado_reg == PRESIONADA) begin
      if (!listo_reg || i_Ack) begin
        tecla_reg <= codigo_tecla(fila_reg, col_reg);
        listo_reg <= 1'b1;
        if (i_Ack) sobre_reg <= 1'b0;
      end else begin
        sobre_reg <= 1'b1;
      end
    end else if (i_Ack && listo_reg) begin
      listo_reg <= 1'b0;
      sobre_reg <= 1'b0;
    end
  end

  assign o_Tecla      = tecla_reg;
  assign o_Listo      = listo_reg;
  assign o_Sobrecarga = sobre_reg;

endmodule

// File: tb/tb_escaner_teclado_4x4.sv
// Bench for escaner_teclado_4x4 with PRESC_LIM=3, DEB_CNT=2.
// Expected codes follow TECLADO_MAPA_HEX_EN when it is defined, raw indices otherwise.
module tb_escaner_teclado_4x4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ack;
  logic [3:0]  filas;
  logic [3:0]  columnas;
  logic [3:0]  tecla;
  logic        listo;
  logic        sobre;
  logic [15:0] teclas;   // pressed keys, index F*4+C

  int          checks = 0;
  int          errors = 0;
  int          rises  = 0;
  logic        listo_prev = 1'b0;
  logic [3:0]  exp_q [$];

  typedef struct {
    int         fila;
    int         fila2;    // second simultaneous row, 4 = none
    int         col;
    logic [3:0] exp_hex;
    logic [3:0] exp_raw;
  } vec_t;

  vec_t       vecs [6];
  logic [3:0] col_tbl [4];

  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    filas = 4'hF;
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < 4; c++)
        if (teclas[f*4+c] && !columnas[c]) filas[f] = 1'b0;
  end

  escaner_teclado_4x4 #(.PRESC_LIM(3), .DEB_CNT(2)) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Filas      (filas),
    .i_Ack        (ack),
    .o_Columnas   (columnas),
    .o_Tecla      (tecla),
    .o_Listo      (listo),
    .o_Sobrecarga (sobre)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // One clock, sampled at the falling edge; o_Listo rising pops the scoreboard.
  task automatic step();
    logic [3:0] e;
    @(negedge clk);
    if (listo && !listo_prev) begin
      rises++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: unexpected o_Listo with o_Tecla=%0h, required no key", tecla);
      end else begin
        e = exp_q.pop_front();
        check("sb_tecla", int'(tecla), int'(e));
      end
    end
    listo_prev = listo;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_listo(input string name, input int budget);
    int i;
    i = 0;
    while (!listo && i < budget) begin
      step();
      i++;
    end
    check(name, int'(listo), 1);
  endtask

  // Stop at the first falling edge after the column switches to column 0.
  task automatic wait_col0();
    int i;
    i = 0;
    while (columnas == 4'b1110 && i < 40) begin step(); i++; end
    while (columnas != 4'b1110 && i < 80) begin step(); i++; end
    check("wait_col0", int'(columnas), int'(4'b1110));
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  function automatic logic [3:0] pick(input logic [3:0] hx, input logic [3:0] rw);
`ifdef TECLADO_MAPA_HEX_EN
    return hx;
`else
    return rw;
`endif
  endfunction

  initial begin
    int r0;
    vecs[0] = '{1, 4, 2, 4'h6, 4'h6};
    vecs[1] = '{1, 2, 3, 4'hB, 4'h7};
    vecs[2] = '{2, 4, 1, 4'h8, 4'h9};
    vecs[3] = '{3, 4, 3, 4'hD, 4'hF};
    vecs[4] = '{3, 4, 1, 4'h0, 4'hD};
    vecs[5] = '{0, 4, 3, 4'hA, 4'h3};
    col_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    rst    = 1'b1;
    ack    = 1'b0;
    teclas = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_columnas", int'(columnas), int'(4'b1110));
    check("rst_tecla", int'(tecla), 0);
    check("rst_listo", int'(listo), 0);
    check("rst_sobre", int'(sobre), 0);
    rst = 1'b0;
    listo_prev = listo;

    // Idle rotation: one column step every 4 clocks.
    check("rot_0", int'(columnas), int'(col_tbl[0]));
    for (int i = 1; i <= 8; i++) begin
      steps(4);
      check("rot_col", int'(columnas), int'(col_tbl[i % 4]));
    end
    check("rot_listo", int'(listo), 0);

    // Table: press, report, ack, keep holding without repeat, release.
    foreach (vecs[i]) begin
      teclas = 16'd0;
      teclas[vecs[i].fila*4 + vecs[i].col] = 1'b1;
      if (vecs[i].fila2 < 4) teclas[vecs[i].fila2*4 + vecs[i].col] = 1'b1;
      exp_q.push_back(pick(vecs[i].exp_hex, vecs[i].exp_raw));
      wait_listo("vec_listo", 100);
      ack_pulse();
      check("vec_ack_clears", int'(listo), 0);
      r0 = rises;
      steps(48);
      check("vec_no_repeat", rises - r0, 0);
      teclas = 16'd0;
      steps(20);
    end

    // Bounce: key at row 0/col 0 seen on a single tick only.
    wait_col0();
    teclas[0] = 1'b1;
    steps(4);
    teclas = 16'd0;
    steps(5);
    check("bounce_col_held", int'(columnas), int'(4'b1110));
    steps(4);
    check("bounce_col_next", int'(columnas), int'(4'b1101));
    r0 = rises;
    steps(40);
    check("bounce_no_key", rises - r0, 0);

    // Overrun: second key while the first is unacknowledged.
    teclas[12] = 1'b1;
    exp_q.push_back(pick(4'hE, 4'hC));
    wait_listo("ovr_first", 100);
    teclas = 16'd0;
    steps(12);
    teclas[14] = 1'b1;
    begin
      int i;
      i = 0;
      while (!sobre && i < 100) begin step(); i++; end
    end
    check("ovr_sobre", int'(sobre), 1);
    check("ovr_tecla_kept", int'(tecla), int'(pick(4'hE, 4'hC)));
    check("ovr_listo", int'(listo), 1);
    ack_pulse();
    check("ovr_ack_listo", int'(listo), 0);
    check("ovr_ack_sobre", int'(sobre), 0);
    teclas = 16'd0;
    steps(20);

    // Reset in REBOTE with an unacknowledged key pending.
    teclas[10] = 1'b1;
    exp_q.push_back(pick(4'h9, 4'hA));
    wait_listo("pre_rst_key", 100);
    teclas = 16'd0;
    steps(20);
    wait_col0();
    teclas[0] = 1'b1;
    steps(6);
    rst = 1'b1;
    #1;
    check("mid_rst_columnas", int'(columnas), int'(4'b1110));
    check("mid_rst_tecla", int'(tecla), 0);
    check("mid_rst_listo", int'(listo), 0);
    step();
    rst = 1'b0;
    r0 = rises;
    steps(10);
    check("post_rst_no_early", rises - r0, 0);
    exp_q.push_back(pick(4'h1, 4'h0));
    wait_listo("post_rst_full_press", 40);
    ack_pulse();
    teclas = 16'd0;
    steps(20);

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/escaner_teclado_4x4.md
# escaner_teclado_4x4

Scans a 4x4 matrix keypad by driving one column low at a time and sampling the four row lines. It debounces key presses and releases, then presents a 4-bit key code through a level ready/acknowledge handshake. It is the input-side counterpart of the multiplexed 7-segment display controller: its codes are hex digits that feed directly into the display data inputs.

## Interface
- `PRESC_LIM`, default 49999: scan tick period is `PRESC_LIM+1` clocks (1 ms at 50 MHz).
- `DEB_CNT`, default 20: number of consecutive stable ticks required for both press and release.
- `i_Clk`  in  1: system clock.
- `i_Rst`  in  1: reset. One clock; reset is asynchronous and active-high.
- `i_Filas`  in  4: keypad row lines, active-low (external pull-ups), asynchronous to `i_Clk`.
- `i_Ack`  in  1: consumer acknowledge; clears `o_Listo`.
- `o_Columnas`  out  4: column drive, one-hot active-low.
- `o_Tecla`  out  4: key code, stable while `o_Listo`=1.
- `o_Listo`  out  1: a new key code is available.
- `o_Sobrecarga`  out  1: sticky flag; a key was lost while `o_Listo`=1.

## Operation
- `i_Filas` passes through a 2-FF synchronizer. Only the synchronized value is used.
- The tick is a one-cycle pulse every `PRESC_LIM+1` clocks. It is free-running and reset to 0.
- Row vector R = the synchronized rows, inverted. The lowest-index active row wins; additional simultaneous rows are ignored.
- FSM states:
  - ESCANEO: on each tick, if R≠0, latch column index C and row index F, clear the debounce counter, and go to REBOTE. Otherwise rotate the column (0→1→2→3→0).
  - REBOTE: column held. On each tick, if the selected row is still active, increment the counter; otherwise return to ESCANEO with the column unchanged. When the count reaches `DEB_CNT`, go to PRESIONADA.
  - PRESIONADA: one cycle. If `o_Listo`=0, load `o_Tecla` and set `o_Listo`. If `o_Listo`=1, drop the key and set `o_Sobrecarga`. Then go to SOLTAR.
  - SOLTAR: column held. On each tick, if R=0, increment the counter, else clear it. At `DEB_CNT`, return to ESCANEO and advance the column.
- Key position index K = F*4 + C.
- Handshake:
  - `o_Listo` and `o_Sobrecarga` clear on the clock after `i_Ack`=1 is sampled.
  - If PRESIONADA and `i_Ack` fall in the same cycle, the ack wins: `o_Listo` is re-set with the new code and no overrun is flagged.
  - `i_Ack` while `o_Listo`=0 has no effect.

## Timing
- Reset values:
  - `o_Columnas`=4'b1110
  - `o_Tecla`=0
  - `o_Listo`=0
  - `o_Sobrecarga`=0
  - state ESCANEO
  - all counters 0
- `o_Columnas` changes only on the cycle after a tick.
- Rows are evaluated at the tick, i.e. after a full column period of settling.
- Press latency: `o_Listo` rises 2 clocks after the tick on which the counter reaches `DEB_CNT` (1 cycle to PRESIONADA, 1 cycle to register).
- Minimum press-to-`o_Listo` time is `(DEB_CNT+1)` ticks plus synchronizer delay.
- A release shorter than `DEB_CNT` ticks does not generate a second key.
- Asserting `i_Rst` mid-debounce or mid-handshake returns everything to reset values immediately; any pending code is lost.

## Configuration
- `TECLADO_MAPA_HEX_EN` defined: K is mapped through the standard layout to its printed hex value:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: E(*) 0 F(#) D
- `TECLADO_MAPA_HEX_EN` undefined: `o_Tecla` = K, the raw position index.

## Structure
- Package `teclado_pkg` holds:
  - the FSM state enum (ESCANEO, REBOTE, PRESIONADA, SOLTAR);
  - the 16-entry key map constant;
  - the default `PRESC_LIM`/`DEB_CNT` values.
- Sub-module `divisor_tick` is parameterized by `PRESC_LIM` and outputs a one-cycle tick.
- The synchronizer, FSM and handshake live in the top module.

## Test plan
Bench parameters: `PRESC_LIM`=3, `DEB_CNT`=2, `TECLADO_MAPA_HEX_EN` defined.
- Reset, no keys: `o_Columnas` cycles 1110→1101→1011→0111→1110, one step every 4 clocks; `o_Listo` stays 0.
- Hold key at row 1, column 2 (row 1 low only while column 2 is driven) for 20 ticks: `o_Listo`=1, `o_Tecla`=4'h6; `i_Ack` pulse → `o_Listo`=0 on the next clock; no repeat while held.
- Key at row 0, column 0, active for only 1 tick (bounce): no `o_Listo`; scanning resumes from column 0.
- Press row 3, column 0, do not ack, release for 3 ticks, then press row 3, column 2: `o_Tecla` stays 4'hE, `o_Sobrecarga`=1; after `i_Ack`, both flags clear.
- Rows 1 and 2 low together at column 3: code 4'hB (lowest row wins).
- Assert `i_Rst` while in REBOTE: outputs return to reset values at once; after release, a full press is needed to report a key.
